// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd2,
    OP_AND    = 4'd3,
    OP_XOR    = 4'd4,
    OP_PASS_B = 4'd5,
    OP_SUB    = 4'd6,
    OP_SHL    = 4'd7,
    OP_SHR    = 4'd8,
    OP_MUL    = 4'd9
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifts and shift-add multiply.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [3:0]       op_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic             shift_carry_reg;
  logic [WIDTH:0]   mul_sum;

  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg          <= '0;
      count_reg       <= '0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      mcand_reg       <= '0;
      shift_carry_reg <= 1'b0;
    end else if (start) begin
      op_reg          <= op;
      count_reg       <= (op == OP_MUL) ? CW'(WIDTH) : CW'(amount);
      hi_reg          <= '0;
      lo_reg          <= (op == OP_MUL) ? b : a;
      mcand_reg       <= a;
      shift_carry_reg <= 1'b0;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
      case (op_reg)
        OP_SHL: begin
          shift_carry_reg <= lo_reg[WIDTH-1];
          lo_reg          <= {lo_reg[WIDTH-2:0], 1'b0};
        end
        OP_SHR: begin
          shift_carry_reg <= lo_reg[0];
          lo_reg          <= {1'b0, lo_reg[WIDTH-1:1]};
        end
        OP_MUL: begin
          // {hi,lo} holds partial product and the not-yet-consumed multiplier bits
          {hi_reg, lo_reg} <= {mul_sum, lo_reg[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign result = lo_reg;
  assign carry  = (op_reg == OP_MUL) ? (|hi_reg) : shift_carry_reg;
  assign done   = (count_reg == CW'(1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops, iterative op dispatch.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             is_zero,
  output logic             carry,
  output logic             busy
);

  state_t           state_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             use_iter_reg;
  logic [WIDTH-1:0] rd_reg;
  logic             zero_reg;
  logic             carry_reg;

  logic             accept;
  logic             start_iter;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] iter_result;
  logic             iter_carry;
  logic             iter_done;

  assign accept     = in_valid && (state_reg == IDLE);
  // shifts by zero finish like single-cycle ops and never start the iterator
  assign start_iter = accept && is_iterative(opcode) &&
                      ((opcode == OP_MUL) || (rs2[SHW-1:0] != '0));

  always_comb begin
    alu_res   = a_reg;
    alu_carry = 1'b0;
    wide      = '0;
    case (op_reg)
      OP_ADD: begin
        wide      = {1'b0, a_reg} + {1'b0, b_reg};
        alu_res   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      OP_SUB: begin
        wide      = {1'b0, a_reg} - {1'b0, b_reg};
        alu_res   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      OP_AND:    alu_res = a_reg & b_reg;
      OP_XOR:    alu_res = a_reg ^ b_reg;
      OP_PASS_B: alu_res = b_reg;
      default:   alu_res = a_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      use_iter_reg <= 1'b0;
      rd_reg       <= '0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          op_reg       <= opcode;
          a_reg        <= rs1;
          b_reg        <= rs2;
          use_iter_reg <= start_iter;
          state_reg    <= EXEC;
        end
        EXEC: begin
          if (!use_iter_reg) begin
            rd_reg    <= alu_res;
            zero_reg  <= (alu_res == '0);
            carry_reg <= alu_carry;
            state_reg <= DONE;
          end else if (iter_done) begin
            state_reg <= DONE;
          end
        end
        DONE: if (out_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_iter),
    .op     (opcode),
    .a      (rs1),
    .b      (rs2),
    .amount (rs2[SHW-1:0]),
    .result (iter_result),
    .carry  (iter_carry),
    .done   (iter_done)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign rd        = use_iter_reg ? iter_result : rd_reg;
  assign is_zero   = use_iter_reg ? (iter_result == '0) : zero_reg;
  assign carry     = use_iter_reg ? iter_carry : carry_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, ov8, or8 = 1, z8, c8, bz8;
  logic [3:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, rd8;
  logic        iv16 = 0, ir16, ov16, or16 = 1, z16, c16, bz16;
  logic [3:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, rd16;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .opcode(op8),
    .rs1(a8), .rs2(b8), .out_valid(ov8), .out_ready(or8), .rd(rd8),
    .is_zero(z8), .carry(c8), .busy(bz8)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .opcode(op16),
    .rs1(a16), .rs2(b16), .out_valid(ov16), .out_ready(or16), .rd(rd16),
    .is_zero(z16), .carry(c16), .busy(bz16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv16 = v; op16 = op; a16 = a; b16 = b;
    end
  endtask

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction
  function automatic logic get_ir(input int w);
    return (w == 8) ? ir8 : ir16;
  endfunction
  function automatic logic [15:0] get_rd(input int w);
    return (w == 8) ? {8'h00, rd8} : rd16;
  endfunction
  function automatic logic get_c(input int w);
    return (w == 8) ? c8 : c16;
  endfunction
  function automatic logic get_z(input int w);
    return (w == 8) ? z8 : z16;
  endfunction

  // Reference: result, flag and latency straight from the operation rules
  task automatic model(input int w, input logic [3:0] op, input longint a, input longint b,
                       output longint r, output bit c, output int lat);
    longint mask, p;
    int n;
    mask = (longint'(1) << w) - 1;
    n    = int'(b % w);
    c    = 0;
    lat  = 2;
    case (op)
      4'd2: begin p = a + b; r = p & mask; c = (p > mask); end
      4'd3: r = a & b;
      4'd4: r = a ^ b;
      4'd5: r = b;
      4'd6: begin r = (a - b) & mask; c = (a < b); end
      4'd7: begin
        r = (a << n) & mask;
        c = (n != 0) ? bit'((a >> (w - n)) & 1) : 1'b0;
        lat = 1 + ((n == 0) ? 1 : n);
      end
      4'd8: begin
        r = a >> n;
        c = (n != 0) ? bit'((a >> (n - 1)) & 1) : 1'b0;
        lat = 1 + ((n == 0) ? 1 : n);
      end
      4'd9: begin p = a * b; r = p & mask; c = ((p >> w) != 0); lat = 1 + w; end
      default: r = a;
    endcase
  endtask

  task automatic wait_ov(input int w, inout int cyc);
    while (!get_ov(w) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input int w, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input string tag);
    longint er;
    bit ec;
    int el, cyc;
    model(w, op, longint'(a), longint'(b), er, ec, el);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, ~op, ~a, ~b);
    cyc = 1;
    wait_ov(w, cyc);
    $display("%s w=%0d op=%0d a=%h b=%h rd=%h c=%b z=%b lat=%0d", tag, w, op, a, b,
             get_rd(w), get_c(w), get_z(w), cyc);
    check({tag, " latency"}, cyc, el);
    check({tag, " rd"}, get_rd(w), er[31:0]);
    check({tag, " carry"}, get_c(w), ec);
    check({tag, " is_zero"}, get_z(w), (er == 0));
    check({tag, " in_ready_done"}, get_ir(w), 0);
    @(posedge clk); #1;
    check({tag, " out_valid_after"}, get_ov(w), 0);
  endtask

  initial begin
    int cyc;
    logic [3:0] rop;
    logic [15:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", ov8, 0);
    check("reset in_ready", ir8, 1);
    check("reset busy", bz8, 0);
    check("reset rd", rd8, 0);
    check("reset is_zero", z8, 0);
    check("reset carry", c8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8, OP_ADD, 16'hF0, 16'h20, "add_carry");
    run_op(8, OP_SUB, 16'h05, 16'h05, "sub_zero");
    run_op(8, OP_SUB, 16'h03, 16'h05, "sub_borrow");
    run_op(8, OP_SHL, 16'h81, 16'h01, "shl_1");
    run_op(8, OP_SHR, 16'h80, 16'h07, "shr_7");
    run_op(8, OP_SHL, 16'h5A, 16'h08, "shl_0");
    run_op(8, OP_MUL, 16'h0F, 16'h11, "mul_ff");
    run_op(8, OP_MUL, 16'h10, 16'h10, "mul_ovf");
    run_op(8, 4'hF, 16'hA5, 16'h3C, "pass_a");
    run_op(8, OP_PASS_B, 16'hA5, 16'h3C, "pass_b");
    run_op(16, OP_ADD, 16'hFFFF, 16'h0001, "add16_wrap");
    run_op(16, OP_MUL, 16'h1234, 16'h00FF, "mul16");

    // reset in the middle of a multiply
    drive(8, 1'b1, OP_MUL, 16'h03, 16'h05);
    @(posedge clk); #1;
    drive(8, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    $display("reset_mid_mul ov=%b ir=%b rd=%h busy=%b", ov8, ir8, rd8, bz8);
    check("rst_mid out_valid", ov8, 0);
    check("rst_mid in_ready", ir8, 1);
    check("rst_mid rd", rd8, 0);
    check("rst_mid busy", bz8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid no result", ov8, 0);
    run_op(8, OP_ADD, 16'h12, 16'h34, "add_after_rst");

    // consumer stall in DONE with a competing request
    or8 = 1'b0;
    drive(8, 1'b1, OP_ADD, 16'h33, 16'h44);
    @(posedge clk); #1;
    drive(8, 1'b1, OP_XOR, 16'h0F, 16'hFF);
    cyc = 1;
    wait_ov(8, cyc);
    check("stall latency", cyc, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("stall cycle=%0d rd=%h ov=%b ir=%b", i, rd8, ov8, ir8);
      check("stall rd", rd8, 8'h77);
      check("stall in_ready", ir8, 0);
      check("stall out_valid", ov8, 1);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    check("no accept in done", bz8, 0);
    check("ready after handshake", ir8, 1);
    @(posedge clk); #1;
    check("accept after handshake", bz8, 1);
    drive(8, 1'b0, 4'h0, 16'h0, 16'h0);
    cyc = 1;
    wait_ov(8, cyc);
    $display("queued_xor rd=%h lat=%0d", rd8, cyc);
    check("queued xor rd", rd8, 8'hF0);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      run_op(8, rop, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, "rand8");
    end
    for (int i = 0; i < 15; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      run_op(16, rop, ra, rb, "rand16");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
